// File: rtl/iic_arb_pkg.sv
// Shared types and constants for the IIC bus arbiter slice.
package iic_arb_pkg;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int PTR_W = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2,
        RELEASE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } arb_op_e;

endpackage

// File: rtl/iic_rr_arbiter.sv
// Winner select for the IIC bus arbiter.
// Default: round-robin starting after the last owner.
// With ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, no pointer.
module iic_rr_arbiter
    import iic_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_pend,
    input  logic [NREQ-1:0] i_owner,
    input  logic            i_advance,
    output logic [NREQ-1:0] o_winner
);

`ifdef ARB_FIXED_PRIO_EN

    // Lowest pending index wins.
    always_comb begin
        logic w_found;
        logic w_hit;
        o_winner = '0;
        w_found  = 1'b0;
        w_hit    = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            w_hit       = !w_found && i_pend[j];
            o_winner[j] = w_hit;
            w_found     = w_found | w_hit;
        end
    end

`else

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;

    // Scan pending requests starting at the pointer, wrapping at NREQ.
    always_comb begin
        logic w_found;
        logic w_hit;
        int   w_idx;
        o_winner = '0;
        w_found  = 1'b0;
        w_hit    = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            w_idx = (w_idx >= NREQ) ? (w_idx - NREQ) : w_idx;
            for (int j = 0; j < NREQ; j++) begin
                w_hit       = !w_found && (j == w_idx) && i_pend[j];
                o_winner[j] = o_winner[j] | w_hit;
                w_found     = w_found | w_hit;
            end
        end
    end

    // Pointer target: the index just after the retiring owner.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int j = 0; j < NREQ; j++) begin
            w_ptr_nxt = i_owner[j] ? ((j == NREQ - 1) ? {PTR_W{1'b0}} : PTR_W'(j + 1)) : w_ptr_nxt;
        end
    end

    // Pointer register, moved only when a transaction is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= {PTR_W{1'b0}};
        end else if (i_advance) begin
            r_ptr <= w_ptr_nxt;
        end else begin
            r_ptr <= r_ptr;
        end
    end

`endif

endmodule

// File: rtl/iic_bus_arbiter.sv
// Shares one iic_controller between NREQ requesters: arbitrates, latches the
// winner's command, drives the controller until ack or watchdog expiry and
// routes ack/err/read data back to the owner. Optional build macro:
// ARB_FIXED_PRIO_EN (fixed priority instead of round-robin, see iic_rr_arbiter).
module iic_bus_arbiter
    import iic_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TO_W        = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wrdb,
    output logic [NREQ-1:0]    req_ack,
    output logic [NREQ-1:0]    req_err,
    output logic [DW-1:0]      req_rddb,
    output logic [NREQ-1:0]    grant,
    output logic               iicwr_req,
    output logic               iicrd_req,
    output logic [AW-1:0]      iic_addr,
    output logic [DW-1:0]      iic_wrdb,
    input  logic [DW-1:0]      iic_rddb,
    input  logic               iic_ack
);

    arb_state_e      r_state, w_state_nxt;
    arb_op_e         r_op, w_op_nxt;
    logic [NREQ-1:0] r_grant, w_grant_nxt;
    logic [NREQ-1:0] r_owner, w_owner_nxt;
    logic [NREQ-1:0] r_ack, w_ack_nxt;
    logic [NREQ-1:0] r_err, w_err_nxt;
    logic [AW-1:0]   r_addr, w_addr_nxt;
    logic [DW-1:0]   r_wrdb, w_wrdb_nxt;
    logic [DW-1:0]   r_rddb, w_rddb_nxt;
    logic [TO_W-1:0] r_cnt, w_cnt_nxt;
    logic            r_iicwr, w_iicwr_nxt;
    logic            r_iicrd, w_iicrd_nxt;

    logic [NREQ-1:0] w_pend;
    logic [NREQ-1:0] w_illegal;
    logic [NREQ-1:0] w_winner;
    logic            w_advance;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wrdb;
    logic            w_sel_illegal;
    logic            w_sel_rd;

    assign w_pend    = req_wr | req_rd;
    assign w_illegal = req_wr & req_rd;
    assign w_advance = (r_state == RELEASE);

    iic_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_pend    (w_pend),
        .i_owner   (r_owner),
        .i_advance (w_advance),
        .o_winner  (w_winner)
    );

    // One-hot mux of the winner's address, data and operation.
    always_comb begin
        w_sel_addr = '0;
        w_sel_wrdb = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_sel_addr = w_sel_addr | (req_addr[i*AW +: AW] & {AW{w_winner[i]}});
            w_sel_wrdb = w_sel_wrdb | (req_wrdb[i*DW +: DW] & {DW{w_winner[i]}});
        end
        w_sel_illegal = |(w_winner & w_illegal);
        w_sel_rd      = |(w_winner & req_rd);
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        w_ack_nxt   = '0;
        w_err_nxt   = '0;
        w_addr_nxt  = r_addr;
        w_wrdb_nxt  = r_wrdb;
        w_rddb_nxt  = r_rddb;
        w_cnt_nxt   = r_cnt;
        w_iicwr_nxt = r_iicwr;
        w_iicrd_nxt = r_iicrd;
        case (r_state)
            IDLE: begin
                if (|w_pend) begin
                    w_owner_nxt = w_winner;
                    if (w_sel_illegal) begin
                        // wr and rd together: reject without touching the bus
                        w_err_nxt   = w_winner;
                        w_state_nxt = RELEASE;
                    end else begin
                        w_grant_nxt = w_winner;
                        w_addr_nxt  = w_sel_addr;
                        w_wrdb_nxt  = w_sel_wrdb;
                        w_op_nxt    = w_sel_rd ? OP_RD : OP_WR;
                        w_state_nxt = ISSUE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                w_iicwr_nxt = (r_op == OP_WR);
                w_iicrd_nxt = (r_op == OP_RD);
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (iic_ack) begin
                    // ack takes precedence over a simultaneous watchdog expiry
                    w_ack_nxt   = r_owner;
                    w_rddb_nxt  = (r_op == OP_RD) ? iic_rddb : r_rddb;
                    w_iicwr_nxt = 1'b0;
                    w_iicrd_nxt = 1'b0;
                    w_state_nxt = RELEASE;
                end else if (r_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                    w_err_nxt   = r_owner;
                    w_iicwr_nxt = 1'b0;
                    w_iicrd_nxt = 1'b0;
                    w_state_nxt = RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + TO_W'(1);
                end
            end
            RELEASE: begin
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_iicwr_nxt = 1'b0;
                w_iicrd_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_owner_nxt = '0;
                w_iicwr_nxt = 1'b0;
                w_iicrd_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched command, registered outputs and watchdog counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_WR;
            r_grant <= '0;
            r_owner <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_addr  <= '0;
            r_wrdb  <= '0;
            r_rddb  <= '0;
            r_cnt   <= '0;
            r_iicwr <= 1'b0;
            r_iicrd <= 1'b0;
        end else begin
            r_op    <= w_op_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_addr  <= w_addr_nxt;
            r_wrdb  <= w_wrdb_nxt;
            r_rddb  <= w_rddb_nxt;
            r_cnt   <= w_cnt_nxt;
            r_iicwr <= w_iicwr_nxt;
            r_iicrd <= w_iicrd_nxt;
        end
    end

    assign req_ack   = r_ack;
    assign req_err   = r_err;
    assign req_rddb  = r_rddb;
    assign grant     = r_grant;
    assign iicwr_req = r_iicwr;
    assign iicrd_req = r_iicrd;
    assign iic_addr  = r_addr;
    assign iic_wrdb  = r_wrdb;

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Directed + randomized bench for iic_bus_arbiter with a transaction-level
// reference model (arbitration order, latched command, ack/timeout timing).
module tb_iic_bus_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_wr, req_rd;
    logic [NREQ*8-1:0] req_addr, req_wrdb;
    logic [NREQ-1:0]   req_ack, req_err, grant;
    logic [7:0]        req_rddb, iic_addr, iic_wrdb, iic_rddb;
    logic              iicwr_req, iicrd_req, iic_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int         m_ptr  = 0;
    logic [7:0] m_rddb = 8'h00;

    iic_bus_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO), .TO_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_wr(req_wr), .req_rd(req_rd), .req_addr(req_addr), .req_wrdb(req_wrdb),
        .req_ack(req_ack), .req_err(req_err), .req_rddb(req_rddb), .grant(grant),
        .iicwr_req(iicwr_req), .iicrd_req(iicrd_req), .iic_addr(iic_addr),
        .iic_wrdb(iic_wrdb), .iic_rddb(iic_rddb), .iic_ack(iic_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_pick(input logic [NREQ-1:0] pend);
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (pend[i]) return i;
`else
        for (int k = 0; k < NREQ; k++) if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
        return 0;
    endfunction

    task automatic m_advance(input int w);
`ifndef ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % NREQ;
`endif
    endtask

    // One legal transaction starting with the DUT in IDLE. The controller
    // model acks in cycle R+d (R = first cycle iic*_req is high); d >= TMO
    // means it never acks.
    task automatic serve(input int d, input logic [7:0] rdval, input bit drop);
        int         w;
        logic [7:0] ea, ed;
        logic [1:0] ereq;
        bit         isrd, hold_ok;
        w    = m_pick(req_wr | req_rd);
        ea   = req_addr[w*8 +: 8];
        ed   = req_wrdb[w*8 +: 8];
        isrd = req_rd[w];
        ereq = isrd ? 2'b01 : 2'b10;
        tick();
        check("grant_n1", grant, 32'd1 << w);
        check("iicreq_n1", {iicwr_req, iicrd_req}, 32'd0);
        tick();
        check("iicreq_n2", {iicwr_req, iicrd_req}, ereq);
        check("iic_addr", iic_addr, ea);
        if (!isrd) check("iic_wrdb", iic_wrdb, ed);
        hold_ok = 1'b1;
        for (int t = 0; t < d && t < TMO; t++) begin
            if (!(({iicwr_req, iicrd_req} === ereq) && (iic_addr === ea) &&
                  (isrd || (iic_wrdb === ed)) && (req_ack === '0) &&
                  (req_err === '0) && (grant === NREQ'(1 << w))))
                hold_ok = 1'b0;
            tick();
        end
        check("hold_wait", hold_ok, 32'd1);
        if (d >= TMO) begin
            check("timeout_err", req_err, 32'd1 << w);
            check("timeout_ack", req_ack, 32'd0);
            check("timeout_drop", {iicwr_req, iicrd_req}, 32'd0);
        end else begin
            iic_ack  = 1'b1;
            iic_rddb = rdval;
            tick();
            iic_ack  = 1'b0;
            iic_rddb = 8'($urandom);
            check("ack_pulse", req_ack, 32'd1 << w);
            check("ack_no_err", req_err, 32'd0);
            if (isrd) begin
                m_rddb = rdval;
                check("rddb", req_rddb, m_rddb);
            end
        end
        m_advance(w);
        if (drop) begin
            req_wr[w] = 1'b0;
            req_rd[w] = 1'b0;
        end
        tick();
        check("release_grant", grant, 32'd0);
        check("release_pulses", {req_ack, req_err}, 32'd0);
        check("release_iic", {iicwr_req, iicrd_req}, 32'd0);
    endtask

    initial begin
        int         w;
        int         mask;
        logic [7:0] stray;
        rst      = 1'b1;
        req_wr   = '0;
        req_rd   = '0;
        req_addr = '0;
        req_wrdb = '0;
        iic_rddb = 8'h00;
        iic_ack  = 1'b0;
        tick();
        tick();
        check("rst_grant", grant, 32'd0);
        check("rst_pulses", {req_ack, req_err}, 32'd0);
        check("rst_iic", {iicwr_req, iicrd_req, iic_addr, iic_wrdb, req_rddb}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: single write
        req_wr[0] = 1'b1; req_addr[7:0] = 8'h02; req_wrdb[7:0] = 8'h59;
        serve(40, 8'h00, 1'b1);

        // 2: read data routed to requester 1
        req_rd[1] = 1'b1; req_addr[15:8] = 8'hE3;
        serve($urandom_range(1, 30), 8'h6C, 1'b1);

        // 3: contention, both hold read requests
        req_rd   = 2'b11;
        req_addr = 16'($urandom);
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_FIXED_PRIO_EN
            check("contention_pick", m_pick(req_rd), 32'd0);
`else
            check("contention_pick", m_pick(req_rd), n % 2);
`endif
            serve($urandom_range(0, 20), 8'($urandom), 1'b0);
        end
        req_rd = '0;

        // 4: timeout on requester 0, requester 1 waiting with a write
        req_rd[0] = 1'b1; req_wr[1] = 1'b1;
        req_addr = 16'($urandom); req_wrdb = 16'($urandom);
        serve(TMO, 8'h00, 1'b1);
        serve($urandom_range(1, 10), 8'h00, 1'b1);

        // 5: illegal request, then reset during WAIT_ACK
        req_wr[0] = 1'b1; req_rd[0] = 1'b1;
        w = m_pick(req_wr | req_rd);
        tick();
        check("illegal_err", req_err, 32'd1 << w);
        check("illegal_grant", grant, 32'd0);
        check("illegal_iic", {iicwr_req, iicrd_req}, 32'd0);
        m_advance(w);
        req_wr[0] = 1'b0; req_rd[0] = 1'b0;
        tick();
        check("illegal_after", {req_err, req_ack, iicwr_req, iicrd_req}, 32'd0);
        req_rd[1] = 1'b1; req_addr[15:8] = 8'($urandom);
        tick();
        check("rst_tx_grant", grant, 32'd2);
        tick();
        check("rst_tx_iicrd", iicrd_req, 32'd1);
        tick(); tick(); tick();
        rst = 1'b1; iic_ack = 1'b1; iic_rddb = 8'h3C;
        tick();
        rst = 1'b0; iic_ack = 1'b0; req_rd = '0;
        m_ptr = 0; m_rddb = 8'h00;
        check("abort_outputs", {grant, req_ack, req_err, iicwr_req, iicrd_req}, 32'd0);
        check("abort_data", {iic_addr, iic_wrdb, req_rddb}, 32'd0);
        tick();
        check("abort_quiet", {grant, req_ack, req_err, iicwr_req, iicrd_req}, 32'd0);

        // 6: ack in the limit cycle, then a stray ack while idle
        req_wr[1] = 1'b1; req_wrdb[15:8] = 8'($urandom);
        serve(TMO - 1, 8'h00, 1'b1);
        stray = 8'($urandom);
        iic_ack = 1'b1; iic_rddb = stray;
        tick();
        iic_ack = 1'b0;
        check("stray_pulses", {req_ack, req_err}, 32'd0);
        check("stray_idle", {grant, iicwr_req, iicrd_req}, 32'd0);
        check("stray_rddb", req_rddb, m_rddb);
        tick();
        check("stray_quiet", {grant, req_ack, req_err}, 32'd0);

        // randomized legal traffic
        for (int n = 0; n < 8; n++) begin
            mask = $urandom_range(1, 3);
            for (int i = 0; i < NREQ; i++) begin
                req_rd[i] = mask[i] & 1'($urandom);
                req_wr[i] = mask[i] & ~req_rd[i];
            end
            req_addr = 16'($urandom);
            req_wrdb = 16'($urandom);
            serve($urandom_range(0, 25), 8'($urandom), 1'b1);
        end
        req_wr = '0; req_rd = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
